// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, keeps up to DEPTH imem requests in flight,
// buffers in-order responses in a prefetch FIFO and drives the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_stall,
  input  logic        i_if_id_stall,
  input  logic        i_if_id_flush,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr
);

  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   pc_q, pc_d;
  fent_t         fifo_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   tagq_q [DEPTH];
  logic [PW-1:0] thead_q, thead_d, ttail_q, ttail_d;
  logic          id_valid_q, id_valid_d;
  logic [31:0]   id_pc_q, id_pc_d;
  logic [31:0]   id_instr_q, id_instr_d;

  logic          pop, rsp, push, grant;
  logic [CW:0]   used;
  logic          unused_rpc;

  assign unused_rpc = ^i_redirect_pc[1:0];

  // Responses with nothing outstanding are stale (e.g. issued before a reset) and ignored.
  assign rsp   = i_imem_rvalid && (out_q != '0);
  assign pop   = (cnt_q != '0) && !i_if_id_stall && !i_if_id_flush && !i_redirect_valid;
  assign push  = rsp && (drop_q == '0) && !i_redirect_valid;
  assign used  = {1'b0, out_q} + {1'b0, cnt_q} - (CW+1)'(pop);

  assign o_imem_req  = i_reset && (used < (CW+1)'(DEPTH)) && !i_pc_stall && !i_redirect_valid;
  assign o_imem_addr = pc_q;
  assign grant       = o_imem_req && i_imem_gnt;

  assign o_id_valid  = id_valid_q;
  assign o_id_pc     = id_pc_q;
  assign o_id_instr  = id_instr_q;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    drop_d  = drop_q;
    thead_d = thead_q;
    ttail_d = ttail_q;

    if (grant) begin
      pc_d    = pc_q + 32'd4;
      ttail_d = ptr_inc(ttail_q);
    end
    if (rsp) thead_d = ptr_inc(thead_q);
    out_d = out_q + CW'(grant) - CW'(rsp);

    if (i_redirect_valid) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      pc_d   = {i_redirect_pc[31:2], 2'b00};
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      drop_d = out_q - CW'(rsp);
    end else begin
      if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (pop)  head_d = ptr_inc(head_q);
      if (push) tail_d = ptr_inc(tail_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (i_redirect_valid || i_if_id_flush) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP;
    end else if (i_if_id_stall) begin
      id_valid_d = id_valid_q;
    end else if (pop) begin
      id_valid_d = 1'b1;
      id_pc_d    = fifo_q[head_q].pc;
      id_instr_d = fifo_q[head_q].instr;
    end else begin
      id_valid_d = 1'b0;
      id_instr_d = NOP;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      thead_q    <= '0;
      ttail_q    <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= RESET_PC;
      id_instr_q <= NOP;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      thead_q    <= thead_d;
      ttail_q    <= ttail_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/counters above.
  always_ff @(posedge i_clk) begin
    if (grant) tagq_q[ttail_q] <= pc_q;
    if (push)  fifo_q[tail_q]  <= '{pc: tagq_q[thead_q], instr: i_imem_rdata};
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table for exact timing, plus an
// in-order imem model and scoreboard of expected IF/ID {pc, instr} for redirect/reset/random runs.
module tb_fetch_stage;

  localparam logic [31:0] MASK     = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_reset, i_pc_stall, i_if_id_stall, i_if_id_flush, i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt, i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_pc, o_id_instr;

  always #5 i_clk = ~i_clk;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_stall(i_pc_stall),
    .i_if_id_stall(i_if_id_stall), .i_if_id_flush(i_if_id_flush),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_id_valid(o_id_valid), .o_id_pc(o_id_pc), .o_id_instr(o_id_instr)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic pcs, ids, fl, rv; logic [31:0] tgt;
    logic e_req; logic [31:0] e_addr; logic e_vld; logic [31:0] e_pc;
  } vec_t;

  exp_t  sb[$];
  mreq_t mq[$];
  int    n_chk = 0, n_pass = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  logic [31:0] model_pc = RESET_PC;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_instr = NOP;
  logic        s_req;
  logic [31:0] s_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: drive at negedge, sample request logic #1 later, check IF/ID #1 after posedge.
  task automatic cycle(input logic rst_n, input logic pcs, input logic ids, input logic fl,
                       input logic rv, input logic [31:0] tgt, input logic gnt);
    int   due;
    exp_t e;
    @(negedge i_clk);
    i_reset = rst_n; i_pc_stall = pcs; i_if_id_stall = ids; i_if_id_flush = fl;
    i_redirect_valid = rv; i_redirect_pc = tgt; i_imem_gnt = gnt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mq[0].addr ^ MASK;
      void'(mq.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr;
    if (!rst_n) begin
      chk("rst_req", o_imem_req, 1'b0);
      chk("rst_id_valid", o_id_valid, 1'b0);
      chk("rst_id_instr", o_id_instr, NOP);
      chk("rst_id_pc", o_id_pc, RESET_PC);
    end else if (rv) begin
      chk("redirect_req", o_imem_req, 1'b0);
    end
    if (rst_n && o_imem_req && gnt) begin
      chk("imem_addr", o_imem_addr, model_pc);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: o_imem_addr, due: due});
      sb.push_back('{pc: model_pc, instr: model_pc ^ MASK});
      model_pc = model_pc + 32'd4;
    end
    if (rv) begin
      sb.delete();
      model_pc = {tgt[31:2], 2'b00};
    end
    if (!rst_n) begin
      sb.delete();
      model_pc = RESET_PC; m_valid = 1'b0; m_pc = RESET_PC; m_instr = NOP;
    end
    @(posedge i_clk); #1;
    cyc++;
    if (!rst_n) begin
      chk("rst_id_valid_q", o_id_valid, 1'b0);
      chk("rst_id_pc_q", o_id_pc, RESET_PC);
    end else if (rv || fl) begin
      chk("kill_id_valid", o_id_valid, 1'b0);
      chk("kill_id_instr", o_id_instr, NOP);
      m_valid = 1'b0; m_instr = NOP;
    end else if (ids) begin
      chk("hold_id_valid", o_id_valid, m_valid);
      chk("hold_id_instr", o_id_instr, m_instr);
      if (m_valid) chk("hold_id_pc", o_id_pc, m_pc);
    end else if (o_id_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL id_unexpected: got valid pc %h, want no valid instruction (cycle %0d)",
                 o_id_pc, cyc);
        m_pc = o_id_pc; m_instr = o_id_instr;
      end else begin
        e = sb.pop_front();
        chk("sb_id_pc", o_id_pc, e.pc);
        chk("sb_id_instr", o_id_instr, e.instr);
        m_pc = e.pc; m_instr = e.instr;
      end
      m_valid = 1'b1;
    end else begin
      chk("idle_id_instr", o_id_instr, NOP);
      m_valid = 1'b0; m_instr = NOP;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[26];
    int   guard;
    // pcs ids fl rv tgt | req addr | vld pc    (1-cycle imem, gnt always high)
    tv[0]  = '{0,0,0,0,32'h0,   1,32'h000, 0,32'h000};
    tv[1]  = '{0,0,0,0,32'h0,   1,32'h004, 0,32'h000};
    tv[2]  = '{0,0,0,0,32'h0,   1,32'h008, 1,32'h000};
    tv[3]  = '{0,0,0,0,32'h0,   1,32'h00C, 1,32'h004};
    tv[4]  = '{0,0,0,0,32'h0,   1,32'h010, 1,32'h008};
    tv[5]  = '{0,1,0,0,32'h0,   0,32'h014, 1,32'h008};
    tv[6]  = '{0,1,0,0,32'h0,   0,32'h014, 1,32'h008};
    tv[7]  = '{0,1,0,0,32'h0,   0,32'h014, 1,32'h008};
    tv[8]  = '{0,1,0,0,32'h0,   0,32'h014, 1,32'h008};
    tv[9]  = '{0,1,0,0,32'h0,   0,32'h014, 1,32'h008};
    tv[10] = '{0,0,0,0,32'h0,   1,32'h014, 1,32'h00C};
    tv[11] = '{0,0,0,0,32'h0,   1,32'h018, 1,32'h010};
    tv[12] = '{0,0,0,0,32'h0,   1,32'h01C, 1,32'h014};
    tv[13] = '{0,0,0,1,32'h103, 0,32'h020, 0,32'h000};
    tv[14] = '{0,0,0,0,32'h0,   1,32'h100, 0,32'h000};
    tv[15] = '{0,0,0,0,32'h0,   1,32'h104, 0,32'h000};
    tv[16] = '{0,0,0,0,32'h0,   1,32'h108, 1,32'h100};
    tv[17] = '{0,0,0,0,32'h0,   1,32'h10C, 1,32'h104};
    tv[18] = '{0,0,1,0,32'h0,   0,32'h110, 0,32'h000};
    tv[19] = '{0,0,0,0,32'h0,   1,32'h110, 1,32'h108};
    tv[20] = '{0,0,0,0,32'h0,   1,32'h114, 1,32'h10C};
    tv[21] = '{0,0,0,0,32'h0,   1,32'h118, 1,32'h110};
    tv[22] = '{1,0,0,0,32'h0,   0,32'h11C, 1,32'h114};
    tv[23] = '{0,0,0,0,32'h0,   1,32'h11C, 1,32'h118};
    tv[24] = '{0,0,0,0,32'h0,   1,32'h120, 0,32'h000};
    tv[25] = '{0,0,0,0,32'h0,   1,32'h124, 1,32'h11C};

    i_reset = 1'b0; i_pc_stall = 1'b0; i_if_id_stall = 1'b0; i_if_id_flush = 1'b0;
    i_redirect_valid = 1'b0; i_redirect_pc = '0; i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    repeat (2) cycle(0, 0, 0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 26; i++) begin
      cycle(1, tv[i].pcs, tv[i].ids, tv[i].fl, tv[i].rv, tv[i].tgt, 1);
      chk($sformatf("tv%0d_req", i), s_req, tv[i].e_req);
      chk($sformatf("tv%0d_addr", i), s_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_id_valid", i), o_id_valid, tv[i].e_vld);
      if (tv[i].e_vld) begin
        chk($sformatf("tv%0d_id_pc", i), o_id_pc, tv[i].e_pc);
        chk($sformatf("tv%0d_id_instr", i), o_id_instr, tv[i].e_pc ^ MASK);
      end
    end

    // Redirect with requests in flight, then a second redirect while drops are pending.
    lat_min = 3; lat_max = 3;
    repeat (8) cycle(1, 0, 0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 0, 1, 32'h100, 1);
    cycle(1, 0, 0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 0, 1, 32'h200, 1);
    repeat (14) cycle(1, 0, 0, 0, 0, 32'h0, 1);

    // Reset with requests outstanding; stale responses land after release.
    repeat (5) cycle(1, 0, 0, 0, 0, 32'h0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 32'h0, 1);
    guard = 0;
    while ((mq.size() > 0 || guard < 3) && guard < 12) begin
      cycle(1, 1, 0, 0, 0, 32'h0, 1);
      guard++;
    end
    chk("stale_rsp_drained", mq.size(), 0);
    repeat (10) cycle(1, 0, 0, 0, 0, 32'h0, 1);

    // Random latency, grant and stalls.
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 1500; k++)
      cycle(1, ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 20) == 0,
            ($urandom % 40) == 0, $urandom, ($urandom % 4) != 0);

    guard = 0;
    while ((sb.size() > 0 || mq.size() > 0) && guard < 60) begin
      cycle(1, 1, 0, 0, 0, 32'h0, 1);
      guard++;
    end
    chk("drain_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
